// File: rtl/logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: op encoding and buffer entry sizing.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

  localparam int FLAG_W = 2;

  // Each buffered entry is {result, all-ones flag, any-one flag}.
  function automatic int entry_w(input int width);
    return width + FLAG_W;
  endfunction

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
interface logic_unit_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_all;
  logic             out_any;

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, out, out_all, out_any
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, out, out_all, out_any
  );
endinterface

// File: rtl/logic_unit_fifo2.sv
// Two-entry valid/ready buffer; entry 0 is always the head and drives the output.
module logic_unit_fifo2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] din_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] dout_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         push, pop;

  assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign dout_o      = e0_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // The head is only overwritten by new data or a shift, so an emptied buffer
  // keeps presenting the last retired entry.
  always_comb begin
    count_d = count_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) e0_d = din_i;
        else                 e1_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) e0_d = e1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = din_i;
        end else begin
          e0_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      count_q <= count_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with XOR accumulator and reduction flags,
// fronted by a valid/ready handshake and backed by a two-entry result buffer.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  logic_unit_if.slave  bus
);

  localparam int EW = entry_w(WIDTH);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_chk
    $error("logic_unit_pipe: WIDTH must be in 1..64");
  end

  op_e              op;
  logic             push;
  logic [WIDTH-1:0] acc_q, acc_d, acc_base;
  logic [WIDTH-1:0] res;
  logic [EW-1:0]    ent_in, ent_out;

  assign op       = op_e'(bus.op);
  assign push     = bus.in_valid && bus.in_ready;
  assign acc_base = bus.acc_clr ? '0 : acc_q;

  always_comb begin
    res = '0;
    case (op)
      OP_AND:  res = bus.a & bus.b;
      OP_OR:   res = bus.a | bus.b;
      OP_NAND: res = ~(bus.a & bus.b);
      OP_NOR:  res = ~(bus.a | bus.b);
      OP_XOR:  res = bus.a ^ bus.b;
      OP_XNOR: res = ~(bus.a ^ bus.b);
      OP_NOT:  res = ~bus.a;
      OP_ACC:  res = acc_base ^ bus.a;
      default: res = '0;
    endcase
  end

  // Non-ACC ops still honour acc_clr, so the next value is acc_base for them.
  assign acc_d = (op == OP_ACC) ? res : acc_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc_q <= '0;
    else if (push) acc_q <= acc_d;
  end

  assign ent_in = {res, &res, |res};

  logic_unit_fifo2 #(.W(EW)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .din_i       (ent_in),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .dout_o      (ent_out)
  );

  assign bus.out     = ent_out[EW-1:2];
  assign bus.out_all = ent_out[1];
  assign bus.out_any = ent_out[0];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed check of logic_unit_pipe against a queue-based reference model.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(W)) bus();

  logic_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         all;
    logic         any;
  } ent_t;

  ent_t         q[$];
  ent_t         last;
  logic [W-1:0] acc;
  int           vecs = 0;
  int           errs = 0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] base);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return base ^ a;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    last = '0;
    acc  = '0;
  endtask

  // One clock: drive, compare all outputs with the model, then advance the model.
  // Returns what the DUT showed: whether it accepted, whether it retired, and the head entry.
  task automatic step(input logic iv, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic clr, input logic ordy,
                      output logic accd, output logic popd, output ent_t pv);
    logic exp_rdy, exp_vld, m_push, m_pop;
    ent_t exp;
    logic [W-1:0] r, base;
    @(negedge clk);
    bus.in_valid = iv; bus.op = op; bus.a = a; bus.b = b;
    bus.acc_clr = clr; bus.out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_vld = (q.size() > 0);
    exp     = exp_vld ? q[0] : last;
    vecs++;
    if (bus.in_ready !== exp_rdy) begin
      errs++; $display("FAIL in_ready: got %b want %b @%0t", bus.in_ready, exp_rdy, $time);
    end
    vecs++;
    if (bus.out_valid !== exp_vld) begin
      errs++; $display("FAIL out_valid: got %b want %b @%0t", bus.out_valid, exp_vld, $time);
    end
    vecs++;
    if ({bus.out, bus.out_all, bus.out_any} !== exp) begin
      errs++; $display("FAIL out/all/any: got %h/%b/%b want %h/%b/%b @%0t",
                       bus.out, bus.out_all, bus.out_any, exp.res, exp.all, exp.any, $time);
    end
    accd = iv && bus.in_ready;
    popd = bus.out_valid && ordy;
    pv   = {bus.out, bus.out_all, bus.out_any};
    m_push = iv && exp_rdy;
    m_pop  = exp_vld && ordy;
    @(posedge clk);
    if (m_pop) last = q.pop_front();
    if (m_push) begin
      base = clr ? '0 : acc;
      r = ref_op(op, a, b, base);
      acc = (op == 3'd7) ? r : base;
      q.push_back({r, &r, |r});
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({bus.out_valid, bus.in_ready, bus.out, bus.out_all, bus.out_any} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      errs++; $display("FAIL reset_state: got vld=%b rdy=%b out=%h all=%b any=%b want 0/1/00/0/0",
                       bus.out_valid, bus.in_ready, bus.out, bus.out_all, bus.out_any);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ops();
    logic [W-1:0] tbl [7];
    logic accd, popd; ent_t pv; int n = 0;
    tbl = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F};
    for (int k = 0; k < 8; k++) begin
      step(k < 7, 3'(k), 8'hF0, 8'hCC, 1'b0, 1'b1, accd, popd, pv);
      if (popd) begin
        vecs++;
        if (n > 6 || pv !== {tbl[n], 1'b0, 1'b1}) begin
          errs++; $display("FAIL ops_result[%0d]: got %h/%b/%b want %h/0/1", n, pv.res, pv.all, pv.any, tbl[n % 7]);
        end
        n++;
      end
    end
    vecs++;
    if (n != 7) begin errs++; $display("FAIL ops_count: got %0d want 7", n); end
  endtask

  task automatic test_acc();
    logic [2:0] ops [4]; logic [W-1:0] as [4]; logic clrs [4]; logic [W-1:0] expv [4];
    logic accd, popd; ent_t pv; int n = 0;
    ops = '{3'd7, 3'd7, 3'd0, 3'd7};
    as = '{8'h55, 8'h0F, 8'h00, 8'h01};
    clrs = '{1'b1, 1'b0, 1'b1, 1'b0};
    expv = '{8'h55, 8'h5A, 8'h00, 8'h01};
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(1'b1, ops[k], as[k], 8'h00, clrs[k], 1'b1, accd, popd, pv);
      else       step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
      if (popd && n < 4) begin
        vecs++;
        if (pv.res !== expv[n]) begin
          errs++; $display("FAIL acc_result[%0d]: got %h want %h", n, pv.res, expv[n]);
        end
        n++;
      end
    end
    vecs++;
    if (n != 4) begin errs++; $display("FAIL acc_count: got %0d want 4", n); end
  endtask

  task automatic test_backpressure();
    logic accd, popd; ent_t pv;
    logic [W-1:0] expv [3]; logic expacc [3];
    expv = '{8'h03, 8'h0C, 8'h30};
    expacc = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd4, 8'h01 << (2*k), 8'h02 << (2*k), 1'b0, 1'b0, accd, popd, pv);
      vecs++;
      if (accd !== expacc[k] || popd !== 1'b0) begin
        errs++; $display("FAIL bp_accept[%0d]: got acc=%b pop=%b want %b/0", k, accd, popd, expacc[k]);
      end
    end
    step(1'b1, 3'd4, 8'h10, 8'h20, 1'b0, 1'b1, accd, popd, pv);
    vecs++;
    if (!accd || !popd || pv.res !== expv[0]) begin
      errs++; $display("FAIL bp_release: got acc=%b pop=%b out=%h want 1/1/%h", accd, popd, pv.res, expv[0]);
    end
    for (int k = 1; k < 3; k++) begin
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
      vecs++;
      if (!popd || pv.res !== expv[k]) begin
        errs++; $display("FAIL bp_drain[%0d]: got pop=%b out=%h want 1/%h", k, popd, pv.res, expv[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic accd, popd; ent_t pv;
    for (int k = 1; k <= 2; k++) step(1'b1, 3'd4, 8'(k), 8'h00, 1'b0, 1'b0, accd, popd, pv);
    for (int k = 3; k <= 6; k++) begin
      step(1'b1, 3'd4, 8'(k), 8'h00, 1'b0, 1'b1, accd, popd, pv);
      vecs++;
      if (!accd || !popd || pv.res !== 8'(k - 2)) begin
        errs++; $display("FAIL full_pushpop[%0d]: got acc=%b pop=%b out=%h want 1/1/%h", k, accd, popd, pv.res, 8'(k - 2));
      end
    end
    // Still full afterwards: with the consumer stalled nothing may enter.
    step(1'b1, 3'd4, 8'h77, 8'h00, 1'b0, 1'b0, accd, popd, pv);
    vecs++;
    if (accd !== 1'b0) begin errs++; $display("FAIL full_still: got acc=%b want 0", accd); end
    for (int k = 5; k <= 6; k++) begin
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
      vecs++;
      if (!popd || pv.res !== 8'(k)) begin
        errs++; $display("FAIL full_drain[%0d]: got pop=%b out=%h want 1/%h", k, popd, pv.res, 8'(k));
      end
    end
  endtask

  task automatic test_reductions();
    logic accd, popd; ent_t pv;
    step(1'b1, 3'd1, 8'hFF, 8'h00, 1'b0, 1'b1, accd, popd, pv);
    step(1'b1, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b1, accd, popd, pv);
    vecs++;
    if (!popd || pv !== {8'hFF, 1'b1, 1'b1}) begin
      errs++; $display("FAIL red_ones: got %h/%b/%b want ff/1/1", pv.res, pv.all, pv.any);
    end
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
    vecs++;
    if (!popd || pv !== {8'h00, 1'b0, 1'b0}) begin
      errs++; $display("FAIL red_zero: got %h/%b/%b want 00/0/0", pv.res, pv.all, pv.any);
    end
  endtask

  task automatic test_reset_mid();
    logic accd, popd; ent_t pv;
    step(1'b1, 3'd7, 8'hA5, 8'h00, 1'b1, 1'b0, accd, popd, pv);
    step(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, accd, popd, pv);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL midreset_state: got vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd7, 8'h01, 8'h00, 1'b0, 1'b1, accd, popd, pv);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
    vecs++;
    if (!popd || pv.res !== 8'h01) begin
      errs++; $display("FAIL midreset_acc: got pop=%b out=%h want 1/01", popd, pv.res);
    end
  endtask

  task automatic test_random();
    logic accd, popd; ent_t pv;
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6, accd, popd, pv);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, accd, popd, pv);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ops();
    test_acc();
    test_backpressure();
    test_back_to_back();
    test_reductions();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
